// File: rtl/tone_sequencer_if.sv
// tone_sequencer_if: table config, sequence control and DAC-side outputs
// of tone_sequencer; master drives control, slave is the sequencer.
interface tone_sequencer_if #(
  parameter int NUM_STEPS = 4
);
  localparam int IW = $clog2(NUM_STEPS);
  localparam int LW = IW + 1;

  logic          CFG_WE;
  logic [IW-1:0] CFG_IDX;
  logic [15:0]   CFG_DIV;
  logic [15:0]   CFG_DUR;
  logic [LW-1:0] SEQ_LEN;
  logic          START;
  logic          STOP;
  logic [7:0]    ROM_ADDR;
  logic          SAMPLE_STB;
  logic          MUTE;
  logic          BUSY;
  logic          DONE;
  logic [IW-1:0] STEP_IDX;

  modport master (
    output CFG_WE, CFG_IDX, CFG_DIV, CFG_DUR,
    output SEQ_LEN, START, STOP,
    input  ROM_ADDR, SAMPLE_STB, MUTE,
    input  BUSY, DONE, STEP_IDX
  );

  modport slave (
    input  CFG_WE, CFG_IDX, CFG_DIV, CFG_DUR,
    input  SEQ_LEN, START, STOP,
    output ROM_ADDR, SAMPLE_STB, MUTE,
    output BUSY, DONE, STEP_IDX
  );
endinterface

// File: rtl/tone_sequencer.sv
// tone_sequencer: plays a table of {divider, duration} tones on a sine ROM.
// Define TONE_GAP_EN to insert GAP_MS of silence between played tones.
module tone_sequencer #(
  parameter int NUM_STEPS = 4,
  parameter int MS_DIV    = 25000,
  parameter int GAP_MS    = 20
) (
  input logic             CLOCK,
  input logic             RESET_N,
  tone_sequencer_if.slave bus
);
  localparam int IW = $clog2(NUM_STEPS);
  localparam int LW = IW + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
`ifdef TONE_GAP_EN
    GAP,
`endif
    FIN
  } state_t;

  state_t        state, state_nx;
  logic [15:0]   div_tab [NUM_STEPS];
  logic [15:0]   dur_tab [NUM_STEPS];
  logic [IW-1:0] step, step_nx;
  logic [LW-1:0] len, len_nx, len_in;
  logic [15:0]   div_cnt, div_nx;
  logic [15:0]   dur_cnt, dur_nx;
  logic [15:0]   ms_cnt, ms_nx;
  logic [7:0]    addr, addr_nx;
  logic          stb, stb_nx;
  logic          mute, busy, done;
  logic          busy_nx;
  logic [15:0]   div_e, dur_e;
  logic          last, skip;

`ifdef TONE_GAP_EN
  localparam int GAP_CYC = GAP_MS * MS_DIV;
  localparam int GW = $clog2(GAP_CYC + 1);
  logic [GW-1:0] gap_cnt, gap_nx;
`endif

  assign div_e  = div_tab[step];
  assign dur_e  = dur_tab[step];
  assign last   = ({1'b0, step} + LW'(1)) == len;
  assign skip   = (div_e == '0) || (dur_e == '0);
  assign len_in = (bus.SEQ_LEN > LW'(NUM_STEPS)) ?
                  LW'(NUM_STEPS) : bus.SEQ_LEN;

  always_comb begin
    state_nx = state;
    step_nx  = step;
    len_nx   = len;
    div_nx   = div_cnt;
    dur_nx   = dur_cnt;
    ms_nx    = ms_cnt;
    addr_nx  = addr;
    stb_nx   = 1'b0;
    busy_nx  = 1'b0;
`ifdef TONE_GAP_EN
    gap_nx   = gap_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (bus.START) begin
          len_nx = len_in;
          if (len_in == '0) begin
            state_nx = FIN;
          end else begin
            step_nx  = '0;
            state_nx = LOAD;
          end
        end
      end
      LOAD: begin
        addr_nx = '0;
        div_nx  = div_e - 16'd1;
        dur_nx  = dur_e;
        ms_nx   = 16'(MS_DIV - 1);
        if (!skip) begin
          state_nx = PLAY;
        end else if (last) begin
          state_nx = FIN;
        end else begin
          step_nx  = step + IW'(1);
          state_nx = LOAD;
        end
      end
      PLAY: begin
        if (div_cnt == '0) begin
          div_nx  = div_e - 16'd1;
          addr_nx = addr + 8'd1;
          stb_nx  = 1'b1;
        end else begin
          div_nx  = div_cnt - 16'd1;
        end
        if (ms_cnt != '0) begin
          ms_nx = ms_cnt - 16'd1;
        end else begin
          ms_nx  = 16'(MS_DIV - 1);
          dur_nx = dur_cnt - 16'd1;
          if (dur_cnt == 16'd1) begin
            if (last) begin
              state_nx = FIN;
            end else begin
              // next tone starts from ROM address 0, no stray strobe
              step_nx = step + IW'(1);
              addr_nx = '0;
              stb_nx  = 1'b0;
`ifdef TONE_GAP_EN
              gap_nx   = GW'(GAP_CYC - 1);
              state_nx = GAP;
`else
              state_nx = LOAD;
`endif
            end
          end
        end
      end
`ifdef TONE_GAP_EN
      GAP: begin
        addr_nx = '0;
        gap_nx  = gap_cnt - GW'(1);
        if (gap_cnt == '0) state_nx = LOAD;
      end
`endif
      FIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.STOP) begin
      state_nx = IDLE;
      addr_nx  = '0;
      stb_nx   = 1'b0;
    end
    busy_nx = (state_nx == LOAD) || (state_nx == PLAY);
`ifdef TONE_GAP_EN
    if (state_nx == GAP) busy_nx = 1'b1;
`endif
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      step    <= '0;
      len     <= '0;
      div_cnt <= '0;
      dur_cnt <= '0;
      ms_cnt  <= '0;
      addr    <= '0;
      stb     <= 1'b0;
      mute    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef TONE_GAP_EN
      gap_cnt <= '0;
`endif
    end else begin
      state   <= state_nx;
      step    <= step_nx;
      len     <= len_nx;
      div_cnt <= div_nx;
      dur_cnt <= dur_nx;
      ms_cnt  <= ms_nx;
      addr    <= addr_nx;
      stb     <= stb_nx;
      mute    <= state_nx != PLAY;
      busy    <= busy_nx;
      done    <= state_nx == FIN;
`ifdef TONE_GAP_EN
      gap_cnt <= gap_nx;
`endif
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        div_tab[i] <= '0;
        dur_tab[i] <= '0;
      end
    end else if (bus.CFG_WE && !busy) begin
      div_tab[bus.CFG_IDX] <= bus.CFG_DIV;
      dur_tab[bus.CFG_IDX] <= bus.CFG_DUR;
    end
  end

  assign bus.ROM_ADDR   = addr;
  assign bus.SAMPLE_STB = stb;
  assign bus.MUTE       = mute;
  assign bus.BUSY       = busy;
  assign bus.DONE       = done;
  assign bus.STEP_IDX   = step;
endmodule
